// File: rtl/lcd_timing_pattern_gen.sv
// 480x272 RGB LCD timing generator: HSYNC/VSYNC/DE, pixel coordinates and a
// per-frame selectable RGB565 test pattern, all registered in the pixel-clock domain.
module lcd_timing_pattern_gen #(
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BP     = 2,
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BP     = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 2,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned BAR_W    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pat_sel,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic       lcd_de,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b,
  output logic [8:0] pix_x,
  output logic [8:0] pix_y,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BPW     = $clog2(BAR_W);

  localparam logic [HW-1:0]  H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0]  H_A0       = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0]  H_A1       = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HW-1:0]  H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0]  V_A0       = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0]  V_A1       = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [VW-1:0]  V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [BPW-1:0] BAR_LAST   = BPW'(BAR_W - 1);
  localparam logic [8:0]     X_LAST     = 9'(H_ACTIVE - 1);
  localparam logic [8:0]     Y_LAST     = 9'(V_ACTIVE - 1);

  logic [HW-1:0]  h_cnt_q, h_cnt_d;
  logic [VW-1:0]  v_cnt_q, v_cnt_d;
  logic [BPW-1:0] bar_px_q, bar_px_d;
  logic [2:0]     bar_idx_q, bar_idx_d;
  logic [1:0]     pat_q, pat_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  logic [15:0]    rgb_q, rgb_d;
  logic [8:0]     pix_x_q, pix_x_d;
  logic [8:0]     pix_y_q, pix_y_d;
  logic           fs_q, fs_d;

  logic           h_act, v_act, act;
  logic [8:0]     x, y;
  logic [15:0]    colour;

  always_comb begin
    h_act = (h_cnt_q >= H_A0) && (h_cnt_q < H_A1);
    v_act = (v_cnt_q >= V_A0) && (v_cnt_q < V_A1);
    act   = h_act && v_act;
    x     = 9'(h_cnt_q - H_A0);
    y     = 9'(v_cnt_q - V_A0);

    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end

    // Bar counter tracks the current h_cnt: cleared as the next count enters
    // the active region, so it reads (0,0) on the first active pixel.
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (h_cnt_d == H_A0) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (h_act) begin
      if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end

    colour = '0;
    case (pat_q)
      2'd0: begin
        case (bar_idx_q)
          3'd0: colour = 16'hFFFF;
          3'd1: colour = 16'hFFE0;
          3'd2: colour = 16'h07FF;
          3'd3: colour = 16'h07E0;
          3'd4: colour = 16'hF81F;
          3'd5: colour = 16'hF800;
          3'd6: colour = 16'h001F;
          default: colour = 16'h0000;
        endcase
      end
      2'd1: colour = 16'hFFFF;
      2'd2: colour = ((x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST)) ? 16'hFFFF : 16'h0000;
      default: colour = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
    endcase

    pat_d   = ((h_cnt_q == '0) && (v_cnt_q == '0)) ? pat_sel : pat_q;
    hsync_d = (h_cnt_q < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_cnt_q < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    de_d    = act;
    rgb_d   = act ? colour : '0;
    pix_x_d = act ? x : '0;
    pix_y_d = act ? y : '0;
    fs_d    = (h_cnt_q == H_A0) && (v_cnt_q == V_A0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      pat_q     <= '0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      de_q      <= 1'b0;
      rgb_q     <= '0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      fs_q      <= 1'b0;
    end else if (en) begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      rgb_q     <= rgb_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      fs_q      <= fs_d;
    end
  end

  assign lcd_hsync   = hsync_q;
  assign lcd_vsync   = vsync_q;
  assign lcd_de      = de_q;
  assign lcd_r       = rgb_q[15:11];
  assign lcd_g       = rgb_q[10:5];
  assign lcd_b       = rgb_q[4:0];
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Directed bench for lcd_timing_pattern_gen: full horizontal timing with a
// shortened vertical frame (2 sync, 1 bp, 12 active, 1 fp lines).
module tb_lcd_timing_pattern_gen;

  localparam int LINE     = 525;
  localparam int FRAME    = 16 * LINE;
  localparam int WAIT_LIM = 2 * FRAME + 100;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] pat_sel;
  logic       lcd_hsync, lcd_vsync, lcd_de, frame_start;
  logic [4:0] lcd_r, lcd_b;
  logic [5:0] lcd_g;
  logic [8:0] pix_x, pix_y;
  logic [15:0] rgb;
  logic [37:0] obs;

  int errors = 0;
  int checks = 0;

  assign rgb = {lcd_r, lcd_g, lcd_b};
  assign obs = {lcd_de, lcd_hsync, lcd_vsync, rgb, pix_x, pix_y, frame_start};

  lcd_timing_pattern_gen #(
    .H_SYNC(41), .H_BP(2), .H_ACTIVE(480), .H_FP(2),
    .V_SYNC(2), .V_BP(1), .V_ACTIVE(12), .V_FP(1),
    .SYNC_POL(1'b0), .BAR_W(60)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WAIT_LIM; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pix(input int px, input int py, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WAIT_LIM; i++) begin
      @(negedge clk);
      if (lcd_de === 1'b1 && pix_x === 9'(px) && pix_y === 9'(py)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; pat_sel = 2'd0;
    repeat (5) @(negedge clk);
    checks++;
    if (obs !== {1'b0, 1'b1, 1'b1, 16'h0, 9'd0, 9'd0, 1'b0}) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, {1'b0, 1'b1, 1'b1, 16'h0, 9'd0, 9'd0, 1'b0});
    end
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_line_timing;
    bit ok; logic prev; int hs_low, de_cnt, de_first, de_last; bit hs_first;
    wait_fs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL line_wait_fs: got timeout expected frame_start"); end
    ok = 1'b0; prev = lcd_hsync;
    for (int i = 0; i < LINE + 10; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && lcd_hsync === 1'b0) begin ok = 1'b1; break; end
      prev = lcd_hsync;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL line_wait_hsync: got timeout expected hsync fall"); end
    for (int ln = 0; ln < 3; ln++) begin
      hs_low = 0; de_cnt = 0; de_first = -1; de_last = -1; hs_first = (lcd_hsync === 1'b0);
      for (int i = 0; i < LINE; i++) begin
        if (lcd_hsync === 1'b0) hs_low++;
        if (lcd_de === 1'b1) begin
          de_cnt++;
          if (de_first < 0) de_first = i;
          de_last = i;
        end
        @(negedge clk);
      end
      checks++;
      if (hs_low != 41 || !hs_first) begin
        errors++; $display("FAIL line%0d_hsync: got low=%0d at_start=%0d expected low=41 at_start=1", ln, hs_low, hs_first);
      end
      checks++;
      if (de_cnt != 480 || de_first != 43 || de_last != 522) begin
        errors++; $display("FAIL line%0d_de: got cnt=%0d first=%0d last=%0d expected 480/43/522", ln, de_cnt, de_first, de_last);
      end
    end
  endtask

  task automatic test_frame_timing;
    bit ok; logic prev, prev_de, last_vs; int vs_low, de_cnt, de_rise, fs_cnt, fs_bad;
    ok = 1'b0; prev = lcd_vsync;
    for (int i = 0; i < WAIT_LIM; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && lcd_vsync === 1'b0) begin ok = 1'b1; break; end
      prev = lcd_vsync;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_wait_vsync: got timeout expected vsync fall"); end
    for (int f = 0; f < 2; f++) begin
      vs_low = 0; de_cnt = 0; de_rise = 0; fs_cnt = 0; fs_bad = 0; prev_de = 1'b0; last_vs = 1'bx;
      for (int i = 0; i < FRAME; i++) begin
        if (lcd_vsync === 1'b0) vs_low++;
        if (lcd_de === 1'b1) de_cnt++;
        if (lcd_de === 1'b1 && prev_de !== 1'b1) de_rise++;
        if (frame_start === 1'b1) begin
          fs_cnt++;
          if (lcd_de !== 1'b1 || pix_x !== 9'd0 || pix_y !== 9'd0) fs_bad++;
        end
        if (i == FRAME - 1) last_vs = lcd_vsync;
        prev_de = lcd_de;
        @(negedge clk);
      end
      checks++;
      if (vs_low != 2 * LINE) begin errors++; $display("FAIL frame%0d_vsync_low: got %0d expected %0d", f, vs_low, 2 * LINE); end
      checks++;
      if (de_rise != 12 || de_cnt != 12 * 480) begin
        errors++; $display("FAIL frame%0d_de: got lines=%0d cycles=%0d expected 12/%0d", f, de_rise, de_cnt, 12 * 480);
      end
      checks++;
      if (fs_cnt != 1 || fs_bad != 0) begin errors++; $display("FAIL frame%0d_fs: got cnt=%0d bad=%0d expected 1/0", f, fs_cnt, fs_bad); end
      checks++;
      if (last_vs !== 1'b1 || lcd_vsync !== 1'b0) begin
        errors++; $display("FAIL frame%0d_period: got end=%b next=%b expected 1/0", f, last_vs, lcd_vsync);
      end
    end
  endtask

  task automatic test_bars;
    bit ok;
    int xs [12] = '{0, 59, 60, 120, 180, 240, 300, 359, 360, 419, 420, 479};
    logic [15:0] cs [12] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F,
                             16'hF800, 16'hF800, 16'h001F, 16'h001F, 16'h0000, 16'h0000};
    wait_fs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bars_wait_fs: got timeout expected frame_start"); end
    for (int i = 0; i < 480; i++) begin
      for (int k = 0; k < 12; k++) begin
        if (xs[k] == i) begin
          checks++;
          if ({pix_x, rgb} !== {9'(i), cs[k]}) begin
            errors++; $display("FAIL bar_x%0d: got x=%0d rgb=%h expected x=%0d rgb=%h", i, pix_x, rgb, i, cs[k]);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({lcd_de, rgb, pix_x} !== {1'b0, 16'h0, 9'd0}) begin
      errors++; $display("FAIL bar_after_line: got de=%b rgb=%h x=%0d expected 0/0000/0", lcd_de, rgb, pix_x);
    end
  endtask

  task automatic test_pattern_latch;
    bit ok;
    wait_pix(60, 6, ok);
    checks++;
    if (!ok || rgb !== 16'hFFE0) begin errors++; $display("FAIL latch_before: got ok=%b rgb=%h expected 1/ffe0", ok, rgb); end
    pat_sel = 2'd3;
    wait_pix(60, 7, ok);
    checks++;
    if (!ok || rgb !== 16'hFFE0) begin errors++; $display("FAIL latch_same_frame: got ok=%b rgb=%h expected 1/ffe0", ok, rgb); end
    wait_pix(0, 0, ok);
    checks++;
    if (!ok || rgb !== 16'h0000 || frame_start !== 1'b1) begin
      errors++; $display("FAIL checker_0_0: got ok=%b rgb=%h fs=%b expected 1/0000/1", ok, rgb, frame_start);
    end
    repeat (16) @(negedge clk);
    checks++;
    if ({pix_x, rgb} !== {9'd16, 16'hFFFF}) begin errors++; $display("FAIL checker_16_0: got x=%0d rgb=%h expected 16/ffff", pix_x, rgb); end
    repeat (16) @(negedge clk);
    checks++;
    if ({pix_x, rgb} !== {9'd32, 16'h0000}) begin errors++; $display("FAIL checker_32_0: got x=%0d rgb=%h expected 32/0000", pix_x, rgb); end
    pat_sel = 2'd2;
  endtask

  task automatic test_border;
    bit ok;
    int px [7] = '{0, 1, 0, 1, 479, 5, 5};
    int py [7] = '{0, 0, 1, 1, 1, 10, 11};
    logic [15:0] ec [7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    for (int k = 0; k < 7; k++) begin
      wait_pix(px[k], py[k], ok);
      checks++;
      if (!ok || rgb !== ec[k]) begin
        errors++; $display("FAIL border_%0d_%0d: got ok=%b rgb=%h expected 1/%h", px[k], py[k], ok, rgb, ec[k]);
      end
    end
    pat_sel = 2'd1;
  endtask

  task automatic test_en_freeze;
    bit ok; int bad;
    wait_pix(100, 3, ok);
    checks++;
    if (!ok || rgb !== 16'hFFFF) begin errors++; $display("FAIL white_100_3: got ok=%b rgb=%h expected 1/ffff", ok, rgb); end
    en = 1'b0; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (obs !== {1'b1, 1'b1, 1'b1, 16'hFFFF, 9'd100, 9'd3, 1'b0}) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL en_frozen: got %0d changed cycles expected 0", bad); end
    en = 1'b1; bad = 0;
    for (int i = 101; i < 480; i++) begin
      @(negedge clk);
      if (lcd_de !== 1'b1 || pix_x !== 9'(i) || pix_y !== 9'd3) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL en_resume: got %0d bad pixels expected 0", bad); end
    @(negedge clk);
    checks++;
    if ({lcd_de, lcd_hsync, rgb} !== {1'b0, 1'b1, 16'h0}) begin
      errors++; $display("FAIL en_fp: got de=%b hs=%b rgb=%h expected 0/1/0000", lcd_de, lcd_hsync, rgb);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (lcd_hsync !== 1'b0) begin errors++; $display("FAIL en_next_hsync: got %b expected 0", lcd_hsync); end
  endtask

  task automatic test_reset_mid;
    bit ok; int k;
    wait_pix(200, 8, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_wait: got timeout expected pixel (200,8)"); end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b0, 1'b1, 1'b1, 16'h0, 9'd0, 9'd0, 1'b0}) begin
      errors++; $display("FAIL rst_async: got %h expected %h", obs, {1'b0, 1'b1, 1'b1, 16'h0, 9'd0, 9'd0, 1'b0});
    end
    repeat (2) @(negedge clk);
    pat_sel = 2'd0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({lcd_hsync, lcd_vsync, lcd_de} !== 3'b000) begin
      errors++; $display("FAIL rst_first_cycle: got hs/vs/de=%b expected 000", {lcd_hsync, lcd_vsync, lcd_de});
    end
    k = 1;
    while (frame_start !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 1619 || {pix_x, pix_y, rgb} !== {9'd0, 9'd0, 16'hFFFF}) begin
      errors++; $display("FAIL rst_clean_frame: got cycle=%0d x=%0d y=%0d rgb=%h expected 1619/0/0/ffff", k, pix_x, pix_y, rgb);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_bars();
    test_pattern_latch();
    test_border();
    test_en_freeze();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
